// File: rtl/mips_cpu_lsu_avalon.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_lsu_avalon
// Purpose  : Load/store unit between the multicycle MIPS core and an Avalon-MM
//            master port. One request at a time: fetch, LB/LBU/LH/LHU/LW,
//            SB/SH/SW (and LD/SD when DATA_W=64). Aligns the bus address,
//            builds byteenable and lane-replicated writedata, and
//            sign/zero-extends read data. Exactly one response per request.
// Option   : define LSU_WAIT_TIMEOUT_EN to abort a bus cycle after MAX_WAIT
//            waitrequest cycles with an error response.
// Ports    : clk, reset            clock / synchronous active-high reset
//            i_req_*  / o_req_ready core request channel
//            o_resp_*               one-cycle response (valid, rdata, err)
//            o_address, o_read, o_write, i_waitrequest, o_writedata,
//            o_byteenable, i_readdata   Avalon-MM master
// Revision : 1.0  initial release
// ============================================================================
module mips_cpu_lsu_avalon #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  // core request
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_write,
  input  logic [1:0]             i_req_size,
  input  logic                   i_req_signed,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [DATA_W-1:0]      i_req_wdata,
  // core response
  output logic                   o_resp_valid,
  output logic [DATA_W-1:0]      o_resp_rdata,
  output logic                   o_resp_err,
  // Avalon-MM master
  output logic [ADDR_W-1:0]      o_address,
  output logic                   o_read,
  output logic                   o_write,
  input  logic                   i_waitrequest,
  output logic [DATA_W-1:0]      o_writedata,
  output logic [DATA_W/8-1:0]    o_byteenable,
  input  logic [DATA_W-1:0]      i_readdata
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LSB    = $clog2(NBYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BUS   = 3'd1,
    S_RDATA = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [LSB-1:0]    r_off;

  logic [LSB-1:0]    w_off;
  logic              w_misaligned;
  logic [NBYTES-1:0] w_lane_mask;
  logic [NBYTES-1:0] w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_keep;
  logic              w_sbit;
  logic [DATA_W-1:0] w_ext;

`ifdef LSU_WAIT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
  logic [CNT_W-1:0]  r_wait_cnt;
`else
  logic [31:0]       w_unused_max_wait;
  assign w_unused_max_wait = MAX_WAIT;
`endif

  // --------------------------------------------------------------------------
  // Request decode (only meaningful in the accept cycle)
  // --------------------------------------------------------------------------
  assign w_off = i_req_addr[LSB-1:0];

  always_comb begin
    w_misaligned = 1'b0;
    w_lane_mask  = '0;
    w_wdata      = i_req_wdata;
    case (i_req_size)
      2'd0: begin
        w_lane_mask = NBYTES'(4'h1);
        w_wdata     = {NBYTES{i_req_wdata[7:0]}};
      end
      2'd1: begin
        w_misaligned = i_req_addr[0];
        w_lane_mask  = NBYTES'(4'h3);
        w_wdata      = {(NBYTES/2){i_req_wdata[15:0]}};
      end
      2'd2: begin
        w_misaligned = |i_req_addr[1:0];
        w_lane_mask  = NBYTES'(4'hF);
        w_wdata      = {(NBYTES/4){i_req_wdata[31:0]}};
      end
      default: begin
        // A doubleword only exists on a 64-bit bus.
        w_misaligned = (DATA_W != 64) || (|i_req_addr[2:0]);
        w_lane_mask  = '1;
        w_wdata      = i_req_wdata;
      end
    endcase
  end

  assign w_be = w_lane_mask << w_off;

  // --------------------------------------------------------------------------
  // Load lane extraction and extension from latched size/offset
  // --------------------------------------------------------------------------
  assign w_shifted = i_readdata >> {r_off, 3'b000};

  always_comb begin
    w_keep = '1;
    w_sbit = 1'b0;
    case (r_size)
      2'd0: begin
        w_keep = DATA_W'(8'hFF);
        w_sbit = w_shifted[7];
      end
      2'd1: begin
        w_keep = DATA_W'(16'hFFFF);
        w_sbit = w_shifted[15];
      end
      2'd2: begin
        w_keep = DATA_W'(32'hFFFF_FFFF);
        w_sbit = w_shifted[31];
      end
      default: begin
        w_keep = '1;
        w_sbit = w_shifted[DATA_W-1];
      end
    endcase
  end

  assign w_ext = (w_shifted & w_keep) | (~w_keep & {DATA_W{r_signed & w_sbit}});

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_off        <= '0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_err   <= 1'b0;
      o_resp_rdata <= '0;
      o_address    <= '0;
      o_read       <= 1'b0;
      o_write      <= 1'b0;
      o_writedata  <= '0;
      o_byteenable <= '0;
`ifdef LSU_WAIT_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      // Response flags are single-cycle pulses.
      o_resp_valid <= 1'b0;
      o_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_size      <= i_req_size;
            r_signed    <= i_req_signed;
            r_off       <= w_off;
            o_req_ready <= 1'b0;
            if (w_misaligned) begin
              r_state      <= S_ERR;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_rdata <= '0;
            end else begin
              r_state      <= S_BUS;
              o_address    <= {i_req_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
              o_byteenable <= w_be;
              o_read       <= ~i_req_write;
              o_write      <= i_req_write;
              if (i_req_write) begin
                o_writedata <= w_wdata;
              end
`ifdef LSU_WAIT_TIMEOUT_EN
              r_wait_cnt   <= '0;
`endif
            end
          end
        end

        S_BUS: begin
`ifdef LSU_WAIT_TIMEOUT_EN
          if (i_waitrequest && (r_wait_cnt == CNT_W'(MAX_WAIT))) begin
            o_read       <= 1'b0;
            o_write      <= 1'b0;
            r_state      <= S_ERR;
            o_resp_valid <= 1'b1;
            o_resp_err   <= 1'b1;
            o_resp_rdata <= '0;
          end else if (i_waitrequest) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
          if (!i_waitrequest) begin
            o_read  <= 1'b0;
            o_write <= 1'b0;
            if (o_write) begin
              r_state      <= S_RESP;
              o_resp_valid <= 1'b1;
              o_resp_rdata <= '0;
            end else begin
              r_state <= S_RDATA;
            end
          end
        end

        S_RDATA: begin
          // readdata is valid in the cycle after the read was accepted.
          o_resp_rdata <= w_ext;
          o_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end

        S_RESP, S_ERR: begin
          o_resp_rdata <= '0;
          o_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          o_read      <= 1'b0;
          o_write     <= 1'b0;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
